// File: rtl/avalon_frame_pkg.sv
// Shared definitions for the LPDDR2 frame read/write masters: FSM states,
// default frame geometry and the frame word-count helper.
package avalon_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_H_ACTIVE  = 1920;
  localparam int DEF_V_ACTIVE  = 1080;
  localparam int DEF_BASE_ADDR = 0;

  function automatic int frame_words(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word is on dout whenever
// empty is low. DEPTH must be a power of 2.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/avalon_frame_reader.sv
// Avalon-MM read master fetching one frame from LPDDR2 and streaming it as
// pixels with SOF/EOL. Define AVALON_FRAME_READER_LOOP_EN for continuous frames.
module avalon_frame_reader
  import avalon_frame_pkg::*;
#(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 32,
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int BASE_ADDR       = DEF_BASE_ADDR,
  parameter int MAX_OUTSTANDING = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              local_init_done,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic              avl_read,
  output logic              avl_burstbegin,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid,
  output logic [23:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        c_state
);

  localparam int FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE);
  localparam int COL_W       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(V_ACTIVE - 1);
  localparam logic [CNT_W:0]    DEPTH_LIM  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  OUT_LIM    = CNT_W'(MAX_OUTSTANDING);

  state_t            state_q, state_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;

  logic              accept;
  logic              push;
  logic              pop;
  logic              last_pop;
  logic              credit;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_count_d;
  logic              unused_hi;

  assign unused_hi = ^avl_readdata[DATA_W-1:24];

  assign accept   = read_q && avl_waitrequest_n;
  assign push     = avl_readdatavalid && (state_q != IDLE) && (out_q != '0);
  assign pop      = !fifo_empty && pix_ready;
  assign last_pop = pop && (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Credit is judged on the occupancy the next cycle will see, so accepts can
  // run back-to-back without overrunning the FIFO.
  assign out_d        = out_q + CNT_W'(accept) - CNT_W'(push);
  assign fifo_count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign credit       = (({1'b0, out_d} + {1'b0, fifo_count_d}) < DEPTH_LIM) &&
                        (out_d < OUT_LIM);

  sync_fifo_fwft #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (push),
    .pop   (pop),
    .din   (avl_readdata[23:0]),
    .dout  (pix_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    addr_d  = addr_q;
    if (accept) addr_d = addr_q + ADDR_W'(1);
    unique case (state_q)
      IDLE: begin
        if (iSTART && local_init_done) begin
          state_d = READ;
          read_d  = 1'b1;
          addr_d  = FIRST_ADDR;
        end
      end
      READ: begin
        if (accept && (addr_q == LAST_ADDR)) begin
          state_d = DRAIN;
          read_d  = 1'b0;
        end else if (!read_q || accept) begin
          // A command already on the bus is never withdrawn.
          read_d = credit;
        end
      end
      DRAIN: begin
        if (last_pop) state_d = DONE;
      end
      DONE: begin
`ifdef AVALON_FRAME_READER_LOOP_EN
        if (local_init_done) begin
          state_d = READ;
          read_d  = 1'b1;
          addr_d  = FIRST_ADDR;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      addr_q  <= FIRST_ADDR;
      out_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      if (pop) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  assign avl_read       = read_q;
  assign avl_burstbegin = read_q;
  assign avl_address    = addr_q;
  assign pix_valid      = !fifo_empty;
  assign pix_sof        = !fifo_empty && (col_q == '0) && (row_q == '0);
  assign pix_eol        = !fifo_empty && (col_q == COL_LAST);
  assign busy           = (state_q != IDLE);
  assign frame_done     = (state_q == DONE);
  assign c_state        = state_q;

endmodule

// File: tb/tb_avalon_frame_reader.sv
// Directed bench for avalon_frame_reader with a 2-cycle-latency memory model
// and a pixel scoreboard.
module tb_avalon_frame_reader;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int FRAME = H * V;
  localparam int DEPTH = 16;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iSTART = 1'b0;
  logic        local_init_done = 1'b1;
  logic        avl_waitrequest_n = 1'b1;
  logic [26:0] avl_address;
  logic        avl_read;
  logic        avl_burstbegin;
  logic [31:0] avl_readdata = '0;
  logic        avl_readdatavalid = 1'b0;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_sof;
  logic        pix_eol;
  logic        busy;
  logic        frame_done;
  logic [1:0]  c_state;

  int total = 0;
  int bad = 0;
  logic [25:0] exp_q[$];
  int acc_cnt = 0;
  int exp_addr = 0;
  int pix_cnt = 0;
  int done_cnt = 0;
  int idle_cnt = 0;
  int stale_n = 0;
  bit wait_mode = 1'b0;
  bit loop_watch = 1'b0;

  always #5 iCLK = ~iCLK;

  avalon_frame_reader #(
    .ADDR_W          (27),
    .DATA_W          (32),
    .H_ACTIVE        (H),
    .V_ACTIVE        (V),
    .BASE_ADDR       (0),
    .MAX_OUTSTANDING (8),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .iSTART            (iSTART),
    .local_init_done   (local_init_done),
    .avl_waitrequest_n (avl_waitrequest_n),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_burstbegin    (avl_burstbegin),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_sof           (pix_sof),
    .pix_eol           (pix_eol),
    .busy              (busy),
    .frame_done        (frame_done),
    .c_state           (c_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: inputs change on the falling edge; data = word address.
  initial begin : mem_model
    bit pv[2];
    int pa[2];
    int hold;
    pv = '{1'b0, 1'b0};
    pa = '{0, 0};
    hold = 0;
    forever begin
      @(negedge iCLK);
      if (stale_n > 0) begin
        avl_readdatavalid = 1'b1;
        avl_readdata = 32'hDE0000 + 32'(stale_n);
        stale_n--;
      end else begin
        avl_readdatavalid = pv[1];
        avl_readdata = 32'(pa[1]);
      end
      pv[1] = pv[0];
      pa[1] = pa[0];
      pv[0] = 1'b0;
      check("burstbegin", 32'(avl_burstbegin), 32'(avl_read));
      if (hold > 0) check("read_held", 32'(avl_read), 32'd1);
      if (avl_read) begin
        check("addr", 32'(avl_address), 32'(exp_addr % FRAME));
        if (wait_mode && hold < 3) begin
          avl_waitrequest_n = 1'b0;
          hold++;
        end else begin
          avl_waitrequest_n = 1'b1;
          hold = 0;
          pv[0] = 1'b1;
          pa[0] = int'(avl_address);
          acc_cnt++;
          exp_addr++;
        end
      end else begin
        avl_waitrequest_n = 1'b1;
      end
    end
  end

  // Pixel scoreboard and event counters.
  initial begin : monitor
    logic [25:0] e;
    forever begin
      @(negedge iCLK);
      if (frame_done) done_cnt++;
      if (loop_watch && c_state == 2'd0) idle_cnt++;
      if (pix_valid && pix_ready) begin
        pix_cnt++;
        if (exp_q.size() == 0) begin
          check("pix_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("pix_data", 32'(pix_data), 32'(e[23:0]));
          check("pix_sof", 32'(pix_sof), 32'(e[25]));
          check("pix_eol", 32'(pix_eol), 32'(e[24]));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic push_frame();
    logic [25:0] e;
    for (int i = 0; i < FRAME; i++) begin
      e = {(i == 0), ((i % H) == H - 1), 24'(i)};
      exp_q.push_back(e);
    end
  endtask

  task automatic new_frame();
    exp_addr = 0;
    acc_cnt = 0;
    pix_cnt = 0;
  endtask

  task automatic start_pulse();
    iSTART = 1'b1;
    tick(1);
    iSTART = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge iCLK);
      n++;
    end
    #1;
    check("done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"}, 32'(avl_read), 32'd0);
    check({tag, "_addr"}, 32'(avl_address), 32'd0);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_sof"}, 32'(pix_sof), 32'd0);
    check({tag, "_eol"}, 32'(pix_eol), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_state"}, 32'(c_state), 32'd0);
  endtask

  task automatic check_frame_end(input string tag, input int done_exp);
    check({tag, "_accepts"}, 32'(acc_cnt), FRAME);
    check({tag, "_pixels"}, 32'(pix_cnt), FRAME);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(c_state), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    tick(5);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(done_exp));
  endtask

  initial begin : stimulus
    int n;
    int left;
    tick(3);
    check_reset_outputs("rst");
    iRST = 1'b0;
    tick(2);

`ifdef AVALON_FRAME_READER_LOOP_EN
    // Three back-to-back frames from one start.
    new_frame();
    push_frame();
    push_frame();
    push_frame();
    start_pulse();
    tick(2);
    loop_watch = 1'b1;
    wait_done(3, 3000);
    loop_watch = 1'b0;
    left = exp_q.size();
    iRST = 1'b1;
    tick(1);
    iRST = 1'b0;
    exp_q.delete();
    check("loop_left", 32'(left), 32'd0);
    check("loop_pixels", 32'(pix_cnt), 32'(3 * FRAME));
    check("loop_no_idle", 32'(idle_cnt), 32'd0);
    check("loop_done_cnt", 32'(done_cnt), 32'd3);
    check_reset_outputs("loop_rst");
    tick(5);
`else
    // Basic frame.
    new_frame();
    push_frame();
    start_pulse();
    wait_done(1, 1000);
    check_frame_end("basic", 1);

    // Waitrequest held low 3 cycles per command.
    wait_mode = 1'b1;
    new_frame();
    push_frame();
    start_pulse();
    wait_done(2, 2000);
    check_frame_end("wait", 2);
    wait_mode = 1'b0;

    // Sink stalled: fetch must stop at FIFO depth.
    pix_ready = 1'b0;
    new_frame();
    push_frame();
    start_pulse();
    tick(100);
    check("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
    check("stall_read_low", 32'(avl_read), 32'd0);
    check("stall_pixels", 32'(pix_cnt), 32'd0);
    pix_ready = 1'b1;
    wait_done(3, 1000);
    check_frame_end("stall", 3);

    // Start ignored without calibration, and mid-frame.
    local_init_done = 1'b0;
    new_frame();
    start_pulse();
    tick(20);
    check("nocal_accepts", 32'(acc_cnt), 32'd0);
    check("nocal_state", 32'(c_state), 32'd0);
    local_init_done = 1'b1;
    push_frame();
    start_pulse();
    tick(10);
    start_pulse();
    wait_done(4, 1000);
    check_frame_end("restart", 4);
    tick(20);
    check("restart_no_rerun", 32'(acc_cnt), FRAME);

    // Reset mid-frame, then stale returns.
    new_frame();
    push_frame();
    start_pulse();
    n = 0;
    while (pix_cnt < 10 && n < 500) begin
      @(posedge iCLK);
      n++;
    end
    #1;
    check("mid_reached", 32'(pix_cnt >= 10), 32'd1);
    iRST = 1'b1;
    tick(1);
    iRST = 1'b0;
    exp_q.delete();
    stale_n = 3;
    check_reset_outputs("mid_rst");
    new_frame();
    tick(8);
    check("stale_dropped", 32'(pix_valid), 32'd0);
    check("stale_pixels", 32'(pix_cnt), 32'd0);
    push_frame();
    start_pulse();
    wait_done(5, 1000);
    check_frame_end("post_rst", 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
